// File: rtl/shared_resource_arbiter.sv
// Two-client round-robin front end for a 1-cycle, one-hot-tagged shared resource.
// Define SHARED_RESOURCE_ARB_ERRCHK_EN to build the sticky protocol checker driving err.
module shared_resource_arbiter #(
    parameter int unsigned DATA_W = 32
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [1:0]          req_valid,
    output logic [1:0]          req_ready,
    input  logic [2*DATA_W-1:0] req_data,
    output logic [1:0]          rsp_valid,
    input  logic [1:0]          rsp_ready,
    output logic [2*DATA_W-1:0] rsp_data,
    output logic [1:0]          res_in_valid,
    output logic [DATA_W-1:0]   res_input,
    input  logic [1:0]          res_out_valid,
    input  logic [DATA_W-1:0]   res_output,
    output logic                err
);

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StWait = 2'd1,
        StResp = 2'd2
    } client_state_e;

    client_state_e             state_q     [2];
    client_state_e             state_d     [2];
    logic          [DATA_W-1:0] rsp_data_q [2];
    logic          [DATA_W-1:0] rsp_data_d [2];
    logic          [1:0]        rsp_valid_q;
    logic          [1:0]        rsp_valid_d;

    logic                       rr_q;
    logic                       rr_d;
    logic          [1:0]        eligible;
    logic          [1:0]        grant;

    logic          [1:0]        res_in_valid_q;
    logic          [1:0]        res_in_valid_d;
    logic          [DATA_W-1:0] res_input_q;
    logic          [DATA_W-1:0] res_input_d;

    // ------------------------------------------------------------------
    // Arbitration
    // ------------------------------------------------------------------
    always_comb begin
        for (int i = 0; i < 2; i++) begin
            eligible[i] = (state_q[i] == StIdle) && req_valid[i];
        end
    end

    // A lone winner hands priority to the other client for the next contention.
    always_comb begin
        grant = 2'b00;
        rr_d  = rr_q;
        unique case (eligible)
            2'b11: begin
                grant = rr_q ? 2'b10 : 2'b01;
                rr_d  = ~rr_q;
            end
            2'b01: begin
                grant = 2'b01;
                rr_d  = 1'b1;
            end
            2'b10: begin
                grant = 2'b10;
                rr_d  = 1'b0;
            end
            default: begin
                grant = 2'b00;
                rr_d  = rr_q;
            end
        endcase
    end

    assign req_ready = grant;

    // ------------------------------------------------------------------
    // Issue stage
    // ------------------------------------------------------------------
    always_comb begin
        res_in_valid_d = grant;
        res_input_d    = res_input_q;
        if (grant[1]) begin
            res_input_d = req_data[DATA_W +: DATA_W];
        end else if (grant[0]) begin
            res_input_d = req_data[0 +: DATA_W];
        end
    end

    // ------------------------------------------------------------------
    // Per-client FSMs and response slots
    // ------------------------------------------------------------------
    always_comb begin
        for (int i = 0; i < 2; i++) begin
            state_d[i]    = state_q[i];
            rsp_data_d[i] = rsp_data_q[i];
            unique case (state_q[i])
                StIdle: begin
                    if (grant[i]) begin
                        state_d[i] = StWait;
                    end
                end
                StWait: begin
                    if (res_out_valid[i]) begin
                        state_d[i]    = StResp;
                        rsp_data_d[i] = res_output;
                    end
                end
                StResp: begin
                    if (rsp_ready[i]) begin
                        state_d[i] = StIdle;
                    end
                end
                default: begin
                    state_d[i] = StIdle;
                end
            endcase
            rsp_valid_d[i] = (state_d[i] == StResp);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rr_q           <= 1'b0;
            res_in_valid_q <= 2'b00;
            res_input_q    <= '0;
            rsp_valid_q    <= 2'b00;
            for (int i = 0; i < 2; i++) begin
                state_q[i]    <= StIdle;
                rsp_data_q[i] <= '0;
            end
        end else begin
            rr_q           <= rr_d;
            res_in_valid_q <= res_in_valid_d;
            res_input_q    <= res_input_d;
            rsp_valid_q    <= rsp_valid_d;
            for (int i = 0; i < 2; i++) begin
                state_q[i]    <= state_d[i];
                rsp_data_q[i] <= rsp_data_d[i];
            end
        end
    end

    assign res_in_valid = res_in_valid_q;
    assign res_input    = res_input_q;
    assign rsp_valid    = rsp_valid_q;
    assign rsp_data     = {rsp_data_q[1], rsp_data_q[0]};

    // ------------------------------------------------------------------
    // Protocol checker
    // ------------------------------------------------------------------
`ifdef SHARED_RESOURCE_ARB_ERRCHK_EN
    logic       err_q;
    logic       err_d;
    logic [1:0] issued_q;

    // issued_q marks the cycle in which the resource must return the tag.
    always_comb begin
        err_d = err_q;
        if (res_out_valid == 2'b11) begin
            err_d = 1'b1;
        end
        for (int i = 0; i < 2; i++) begin
            if (res_out_valid[i] && (state_q[i] != StWait)) begin
                err_d = 1'b1;
            end
            if (issued_q[i] && (state_q[i] == StWait) && !res_out_valid[i]) begin
                err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err_q    <= 1'b0;
            issued_q <= 2'b00;
        end else begin
            err_q    <= err_d;
            issued_q <= res_in_valid_q;
        end
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_shared_resource_arbiter.sv
// Directed bench for shared_resource_arbiter with a 1-cycle doubling resource model.
module tb_shared_resource_arbiter;

    localparam int unsigned DW = 32;

    logic            clk = 1'b0;
    logic            reset = 1'b0;
    logic [1:0]      req_valid;
    logic [1:0]      req_ready;
    logic [2*DW-1:0] req_data;
    logic [1:0]      rsp_valid;
    logic [1:0]      rsp_ready;
    logic [2*DW-1:0] rsp_data;
    logic [1:0]      res_in_valid;
    logic [DW-1:0]   res_input;
    logic [1:0]      res_out_valid;
    logic [DW-1:0]   res_output;
    logic            err;

    logic [1:0]      mdl_valid;
    logic [DW-1:0]   mdl_data;
    logic [1:0]      inj;

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    shared_resource_arbiter #(.DATA_W(DW)) dut (
        .clk          (clk),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_data     (req_data),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_data     (rsp_data),
        .res_in_valid (res_in_valid),
        .res_input    (res_input),
        .res_out_valid(res_out_valid),
        .res_output   (res_output),
        .err          (err)
    );

    // Resource: one-cycle latency, doubles the operand, truncated to DW bits.
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            mdl_valid <= 2'b00;
            mdl_data  <= '0;
        end else begin
            mdl_valid <= res_in_valid;
            mdl_data  <= res_input << 1;
        end
    end

    assign res_out_valid = mdl_valid | inj;
    assign res_output    = mdl_data;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #4;
    endtask

    task automatic do_reset();
        tick();
        reset     = 1'b1;
        req_valid = 2'b00;
        settle();
        tick();
        reset = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        logic [1:0] exp_ready;
        logic [1:0] exp_rv;

        req_valid = 2'b00;
        req_data  = '0;
        rsp_ready = 2'b00;
        inj       = 2'b00;
        #1 reset  = 1'b1;
        #2;
        check_eq("rst_ready", req_ready, 2'b00);
        check_eq("rst_rsp_valid", rsp_valid, 2'b00);
        check_eq("rst_rsp_data", rsp_data, 64'h0);
        check_eq("rst_res_in_valid", res_in_valid, 2'b00);
        check_eq("rst_res_input", res_input, 32'h0);
        check_eq("rst_err", err, 1'b0);

        // Single request from client 0.
        tick();
        reset          = 1'b0;
        req_valid      = 2'b01;
        req_data[31:0] = 32'h5;
        rsp_ready      = 2'b11;
        settle();
        check_eq("single_ready", req_ready, 2'b01);
        tick();
        req_valid = 2'b00;
        settle();
        check_eq("single_issue_v", res_in_valid, 2'b01);
        check_eq("single_issue_d", res_input, 32'h5);
        check_eq("single_ready_off", req_ready, 2'b00);
        tick();
        settle();
        check_eq("single_issue_drop", res_in_valid, 2'b00);
        check_eq("single_no_early_rsp", rsp_valid, 2'b00);
        tick();
        settle();
        check_eq("single_rsp_v", rsp_valid, 2'b01);
        check_eq("single_rsp_d", rsp_data[31:0], 32'hA);
        tick();
        settle();
        check_eq("single_idle", rsp_valid, 2'b00);

        // rr now points at client 1.
        tick();
        req_valid = 2'b11;
        settle();
        check_eq("rr_after_single", req_ready, 2'b10);

        // Contention from reset.
        do_reset();
        req_valid = 2'b11;
        req_data  = {32'h20, 32'h10};
        rsp_ready = 2'b11;
        settle();
        check_eq("cont_ready0", req_ready, 2'b01);
        tick();
        req_valid = 2'b10;
        settle();
        check_eq("cont_ready1", req_ready, 2'b10);
        check_eq("cont_issue0_v", res_in_valid, 2'b01);
        check_eq("cont_issue0_d", res_input, 32'h10);
        tick();
        req_valid = 2'b00;
        settle();
        check_eq("cont_issue1_v", res_in_valid, 2'b10);
        check_eq("cont_issue1_d", res_input, 32'h20);
        tick();
        settle();
        check_eq("cont_rsp0_v", rsp_valid, 2'b01);
        check_eq("cont_rsp0_d", rsp_data[31:0], 32'h20);
        tick();
        settle();
        check_eq("cont_rsp1_v", rsp_valid, 2'b10);
        check_eq("cont_rsp1_d", rsp_data[63:32], 32'h40);
        tick();
        settle();
        check_eq("cont_idle", rsp_valid, 2'b00);

        // Client 0 stalled in RESP while client 1 streams 1, 2, 3.
        do_reset();
        for (int k = 0; k < 14; k++) begin
            if (k > 0) tick();
            req_valid       = (k == 0) ? 2'b01 : ((k <= 9) ? 2'b10 : 2'b00);
            req_data[31:0]  = 32'h7;
            req_data[63:32] = (k <= 4) ? 32'h1 : ((k <= 8) ? 32'h2 : 32'h3);
            rsp_ready       = 2'b10;
            settle();
            exp_ready = (k == 0) ? 2'b01 :
                        ((k == 1 || k == 5 || k == 9) ? 2'b10 : 2'b00);
            exp_rv    = {(k == 4 || k == 8 || k == 12), (k >= 3)};
            check_eq($sformatf("stall_ready_%0d", k), req_ready, exp_ready);
            check_eq($sformatf("stall_rsp_v_%0d", k), rsp_valid, exp_rv);
            if (k >= 3) check_eq($sformatf("stall_hold0_%0d", k), rsp_data[31:0], 32'hE);
            if (exp_rv[1]) begin
                check_eq($sformatf("stall_rsp1_d_%0d", k), rsp_data[63:32], 32'((k / 4) * 2));
            end
        end
        tick();
        req_valid = 2'b00;
        rsp_ready = 2'b11;
        settle();
        check_eq("stall_release_v", rsp_valid, 2'b01);
        tick();
        settle();
        check_eq("stall_released", rsp_valid, 2'b00);

        // Result wraps to DATA_W bits.
        tick();
        req_valid      = 2'b01;
        req_data[31:0] = 32'h8000_0001;
        settle();
        check_eq("wrap_ready", req_ready, 2'b01);
        tick();
        req_valid = 2'b00;
        tick();
        tick();
        settle();
        check_eq("wrap_rsp_v", rsp_valid, 2'b01);
        check_eq("wrap_rsp_d", rsp_data[31:0], 32'h2);
        check_eq("wrap_no_err", err, 1'b0);
        tick();
        settle();
        check_eq("wrap_idle", rsp_valid, 2'b00);

        // Reset asserted the cycle after issue.
        tick();
        req_valid       = 2'b10;
        req_data[63:32] = 32'h55;
        settle();
        check_eq("mid_ready", req_ready, 2'b10);
        tick();
        req_valid = 2'b00;
        settle();
        check_eq("mid_issue_v", res_in_valid, 2'b10);
        reset = 1'b1;
        #1;
        check_eq("mid_rst_in_v", res_in_valid, 2'b00);
        check_eq("mid_rst_input", res_input, 32'h0);
        check_eq("mid_rst_rsp_v", rsp_valid, 2'b00);
        check_eq("mid_rst_rsp_d", rsp_data, 64'h0);
        check_eq("mid_rst_err", err, 1'b0);
        tick();
        reset = 1'b0;
        for (int k = 0; k < 5; k++) begin
            settle();
            check_eq($sformatf("mid_after_%0d", k), rsp_valid, 2'b00);
            tick();
        end

        // Stray tag for an idle client.
        inj = 2'b10;
        settle();
        check_eq("inj_err_pre", err, 1'b0);
        tick();
        inj = 2'b00;
        settle();
`ifdef SHARED_RESOURCE_ARB_ERRCHK_EN
        check_eq("inj_err_set", err, 1'b1);
`else
        check_eq("inj_err_tied", err, 1'b0);
`endif
        check_eq("inj_rsp_v", rsp_valid, 2'b00);
        tick();
        tick();
        req_valid = 2'b10;
        settle();
`ifdef SHARED_RESOURCE_ARB_ERRCHK_EN
        check_eq("inj_err_held", err, 1'b1);
`else
        check_eq("inj_err_held", err, 1'b0);
`endif
        check_eq("inj_fsm_idle", req_ready, 2'b10);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
